// File: rtl/pixel_word_packer.sv
// pixel_word_packer: requests a frame from the test-image source, packs 8-bit pixels 4-per-word, queues addressed 32-bit words for the frame-buffer writer.
// Latency: the 4th pixel accept pushes the word into the FIFO; wr_valid rises on the next cycle (registered FIFO storage).
// Backpressure: in_ready drops when the FIFO is full and no pop is happening in the same cycle; wr_addr/wr_data hold while wr_ready is low.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   frame_start             one-cycle request to capture a frame, ignored while busy
//   busy, frame_done        frame in progress / one-cycle pulse after the last word handshake
//   src_start/src_start_ack start handshake toward the image source
//   in_valid/in_ready/in_pixel   8-bit pixel stream from the source
//   wr_valid/wr_ready/wr_addr/wr_data   addressed word writes toward memory
// Optional build macro PIXEL_PACKER_STATS_EN adds stall_cycles and src_idle_cycles outputs.
module pixel_word_packer #(
    parameter int                    FRAME_PIXELS = 480000,
    parameter int                    ADDR_WIDTH   = 17,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  src_start,
    input  logic                  src_start_ack,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_pixel,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data
`ifdef PIXEL_PACKER_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           src_idle_cycles
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PIX_W = $clog2(FRAME_PIXELS + 1);

    localparam logic [CNT_W-1:0] FIFO_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FIFO_ONE     = CNT_W'(1);
    localparam logic [PIX_W-1:0] LAST_PIX_IDX = PIX_W'(FRAME_PIXELS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_DROP   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [1:0]            lane_q, lane_d;
    // Lanes 0..2 only; lane 3 goes straight from in_pixel into the FIFO entry.
    logic [23:0]           pack_q, pack_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  frame_done_q, frame_done_d;

    logic [31:0]           fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic        frame_accept;
    logic        accept;
    logic        push;
    logic        pop;
    logic        last_pixel;
    logic [31:0] push_data;

    assign frame_accept = (state_q == S_IDLE) && frame_start;
    assign wr_valid     = (count_q != '0);
    assign pop          = wr_valid && wr_ready;
    // A same-cycle pop frees an entry, so a full FIFO can still take a pixel.
    assign in_ready     = (state_q == S_STREAM) && ((count_q != FIFO_FULL) || pop);
    assign accept       = in_valid && in_ready;
    assign push         = accept && (lane_q == 2'd3);
    assign push_data    = {in_pixel, pack_q};
    assign last_pixel   = accept && (pix_cnt_q == LAST_PIX_IDX);

    assign busy       = (state_q != S_IDLE);
    assign src_start  = (state_q == S_REQ);
    assign frame_done = frame_done_q;
    // Gate the head entry so the outputs read as idle values whenever the FIFO is empty.
    assign wr_data    = wr_valid ? fifo_data_q[rd_ptr_q] : 32'd0;
    assign wr_addr    = wr_valid ? fifo_addr_q[rd_ptr_q] : addr_q;

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE:   if (frame_start)    state_d = S_REQ;
            S_REQ:    if (src_start_ack)  state_d = S_DROP;
            S_DROP:   if (!src_start_ack) state_d = S_STREAM;
            S_STREAM: if (last_pixel)     state_d = S_DRAIN;
            S_DRAIN: begin
                // Nothing is pushed in DRAIN, so popping the last entry empties the FIFO.
                if (pop && (count_q == FIFO_ONE)) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default:                      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        lane_d    = lane_q;
        pack_d    = pack_q;
        addr_d    = addr_q;
        if (frame_accept) begin
            pix_cnt_d = '0;
            lane_d    = 2'd0;
            pack_d    = 24'd0;
            addr_d    = BASE_ADDR;
        end else if (accept) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
            lane_d    = lane_q + 2'd1;
            case (lane_q)
                2'd0:    pack_d[7:0]   = in_pixel;
                2'd1:    pack_d[15:8]  = in_pixel;
                2'd2:    pack_d[23:16] = in_pixel;
                default: pack_d        = pack_q;
            endcase
            if (push) begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pix_cnt_q    <= '0;
            lane_q       <= 2'd0;
            pack_q       <= 24'd0;
            addr_q       <= BASE_ADDR;
            frame_done_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            addr_q       <= addr_d;
            frame_done_q <= frame_done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once written and counted.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_addr_q[wr_ptr_q] <= addr_q;
        end
    end

`ifdef PIXEL_PACKER_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] idle_q;

    always_ff @(posedge clock) begin
        if (reset || frame_accept) begin
            stall_q <= 32'd0;
            idle_q  <= 32'd0;
        end else begin
            if (wr_valid && !wr_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            // in_ready already implies STREAM.
            if (in_ready && !in_valid && (idle_q != 32'hFFFF_FFFF)) begin
                idle_q <= idle_q + 32'd1;
            end
        end
    end

    assign stall_cycles    = stall_q;
    assign src_idle_cycles = idle_q;
`endif

endmodule
